mdio_master: RTL and testbench

Parametrised IEEE 802.3 MDIO management master with integrated PHY reset sequencer, replacing direct PS-GEM MDIO pin pass-through on Ethernet designs. Accepts register commands over a valid/ready interface, generates MDC, and serialises Clause 22 or Clause 45 frames onto the split mdio_o/mdio_t/mdio_i triple that feeds the top-level IOBUF. Also owns phy_rst_n: it holds the PHY in reset after power-up or on request, and blocks commands until the PHY is released.

---
 rtl/mdio_pkg.sv | 40 ++++
 rtl/mdio_clkgen.sv | 38 +++
 rtl/mdio_master.sv | 205 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, frame layout and state encoding for the MDIO management master.
package mdio_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned TA_BIT     = 14;
    localparam int unsigned DATA_BIT   = 16;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    localparam logic [1:0] OP_C22_WRITE    = 2'b01;
    localparam logic [1:0] OP_C22_READ     = 2'b10;
    localparam logic [1:0] OP_C45_ADDR     = 2'b00;
    localparam logic [1:0] OP_C45_WRITE    = 2'b01;
    localparam logic [1:0] OP_C45_READ     = 2'b11;
    localparam logic [1:0] OP_C45_READ_INC = 2'b10;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        PRE,
        FRAME,
        DONE
    } state_e;

    // Bit order on the wire is MSB first, so field order here is wire order.
    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [1:0]  ta;
        logic [15:0] data;
    } mdio_frame_t;

    function automatic logic is_read_op(input logic c45, input logic [1:0] op);
        return c45 ? op[1] : (op == OP_C22_READ);
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: divides clk by 2*CLK_DIV while enabled and flags the fall/rise cycles.
module mdio_clkgen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic fall_stb,
    output logic rise_stb,
    output logic mdc
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV);

    logic [CW-1:0] cnt_q;

    assign rise_stb = en && (cnt_q == CW'(CLK_DIV - 1));
    assign fall_stb = en && (cnt_q == CW'(2 * CLK_DIV - 1));

    // Disabled divider parks at the start of a low half-cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc   <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            mdc   <= 1'b0;
        end else begin
            cnt_q <= fall_stb ? '0 : cnt_q + CW'(1);
            if (rise_stb) begin
                mdc <= 1'b1;
            end else if (fall_stb) begin
                mdc <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mdio_master.sv
// MDIO Clause 22/45 management master with PHY reset sequencer.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned PRE_LEN    = 32,
    parameter int unsigned RST_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    input  logic        phy_rst_req,
    output logic        phy_rst_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);

    localparam int unsigned CNT_W = $clog2(PRE_LEN + FRAME_BITS + 1);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [RST_W-1:0]      rcnt_q, rcnt_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [15:0]           rd_q, rd_d;
    logic                  is_rd_q, is_rd_d;
    logic                  pend_q, pend_d;
    logic                  err_q, err_d;
    logic                  mdio_o_d, mdio_t_d;
    logic                  rsp_valid_d, rsp_err_d;
    logic [15:0]           rsp_data_d;
    logic                  fall_stb, rise_stb, clk_en_c, rd_op_c;
    mdio_frame_t           frame_c;

    assign clk_en_c = (state_q == PRE) || (state_q == FRAME);

    mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en_c),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb),
        .mdc      (mdc)
    );

    // Read frames release the line for TA/DATA, so their driven TA/DATA is don't-care.
    always_comb begin
        rd_op_c       = is_read_op(cmd_c45, cmd_op);
        frame_c.st    = cmd_c45 ? ST_C45 : ST_C22;
        frame_c.op    = cmd_op;
        frame_c.phyad = cmd_phy;
        frame_c.regad = cmd_reg;
        frame_c.ta    = rd_op_c ? 2'b11 : 2'b10;
        frame_c.data  = rd_op_c ? 16'hFFFF : cmd_data;
    end

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        rcnt_d      = rcnt_q;
        sh_d        = sh_q;
        rd_d        = rd_q;
        is_rd_d     = is_rd_q;
        pend_d      = pend_q;
        err_d       = err_q;
        mdio_o_d    = mdio_o;
        mdio_t_d    = mdio_t;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;

        case (state_q)
            RST_HOLD: begin
                if (rcnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q + RST_W'(1);
                end
            end
            IDLE: begin
                mdio_o_d = 1'b1;
                mdio_t_d = 1'b1;
                if (phy_rst_req) begin
                    state_d = RST_HOLD;
                    rcnt_d  = '0;
                end else if (cmd_valid) begin
                    sh_d     = frame_c;
                    is_rd_d  = rd_op_c;
                    err_d    = 1'b0;
                    rd_d     = '0;
                    bit_d    = '0;
                    mdio_t_d = 1'b0;
                    if (PRE_LEN == 0) begin
                        state_d  = FRAME;
                        mdio_o_d = frame_c.st[1];
                    end else begin
                        state_d  = PRE;
                        mdio_o_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (phy_rst_req) pend_d = 1'b1;
                if (fall_stb) begin
                    if (bit_q == CNT_W'(PRE_LEN - 1)) begin
                        state_d  = FRAME;
                        bit_d    = '0;
                        mdio_o_d = sh_q[FRAME_BITS-1];
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end
            FRAME: begin
                if (phy_rst_req) pend_d = 1'b1;
                // Second TA bit and data bits are sampled as mdc rises.
                if (rise_stb && is_rd_q) begin
                    if ((bit_q == CNT_W'(TA_BIT + 1)) && mdio_i) err_d = 1'b1;
                    if (bit_q >= CNT_W'(DATA_BIT)) rd_d = {rd_q[14:0], mdio_i};
                end
                if (fall_stb) begin
                    if (bit_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = is_rd_q ? rd_q : 16'h0000;
                        rsp_err_d   = err_q;
                        mdio_o_d    = 1'b1;
                        mdio_t_d    = 1'b1;
                    end else begin
                        bit_d    = bit_q + CNT_W'(1);
                        sh_d     = sh_q << 1;
                        mdio_o_d = sh_q[FRAME_BITS-2];
                        mdio_t_d = is_rd_q && (bit_d >= CNT_W'(TA_BIT));
                    end
                end
            end
            DONE: begin
                mdio_o_d = 1'b1;
                mdio_t_d = 1'b1;
                if (pend_q || phy_rst_req) begin
                    state_d = RST_HOLD;
                    rcnt_d  = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RST_HOLD;
                rcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_HOLD;
            bit_q     <= '0;
            rcnt_q    <= '0;
            sh_q      <= '0;
            rd_q      <= '0;
            is_rd_q   <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            phy_rst_n <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_t    <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            rcnt_q    <= rcnt_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            is_rd_q   <= is_rd_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            phy_rst_n <= (state_d != RST_HOLD);
            mdio_o    <= mdio_o_d;
            mdio_t    <= mdio_t_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: index 0 runs with a 32-bit preamble, index 1 with none.
module tb_mdio_master;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned RST_CYCLES = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_c45 = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_phy = '0;
    logic [4:0]  cmd_reg = '0;
    logic [15:0] cmd_data = '0;
    logic [1:0]  cmd_valid = 2'b00;
    logic [1:0]  phy_rst_req = 2'b00;
    logic [1:0]  mdio_i = 2'b11;

    wire [1:0]   cmd_ready, rsp_valid, rsp_err, busy, phy_rst_n, mdc, mdio_o, mdio_t;
    wire [15:0]  rsp_data0, rsp_data1;

    int          n_vec = 0;
    int          n_err = 0;

    logic [63:0] cap_o, cap_t;
    int          n_rv, rv_cyc;
    logic [15:0] rv_data;
    logic        rv_err, rdy_after;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(32), .RST_CYCLES(RST_CYCLES)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data0),
        .rsp_err(rsp_err[0]), .busy(busy[0]), .phy_rst_req(phy_rst_req[0]),
        .phy_rst_n(phy_rst_n[0]), .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_t(mdio_t[0]),
        .mdio_i(mdio_i[0])
    );

    mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(0), .RST_CYCLES(RST_CYCLES)) u_dut_np (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_c45(cmd_c45), .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data1),
        .rsp_err(rsp_err[1]), .busy(busy[1]), .phy_rst_req(phy_rst_req[1]),
        .phy_rst_n(phy_rst_n[1]), .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_t(mdio_t[1]),
        .mdio_i(mdio_i[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rst_vec(input int d);
        return {phy_rst_n[d], cmd_ready[d], busy[d], mdc[d], mdio_o[d], mdio_t[d],
                rsp_valid[d], rsp_err[d], (d == 0) ? rsp_data0 : rsp_data1};
    endfunction

    // Issue one command, act as the PHY, and record wire bits at each mdc rise.
    // inj=1 pulses phy_rst_req at cycle 150 after the handshake.
    task automatic run_frame(input int d, input logic c45, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] data, input logic drive, input logic ta2,
                             input logic [15:0] pdata, input int inj);
        int   pre = (d == 0) ? 32 : 0;
        int   len = (pre + 32) * 2 * int'(CLK_DIV);
        int   nf = 0;
        int   fb;
        int   wait_c = 0;
        logic pm = 1'b0;
        cap_o = '0; cap_t = '0; n_rv = 0; rv_cyc = 0; rv_data = '0; rv_err = 1'b0;
        rdy_after = 1'b0;
        @(negedge clk);
        cmd_c45 = c45; cmd_op = op; cmd_phy = phy; cmd_reg = regad; cmd_data = data;
        cmd_valid[d] = 1'b1;
        while (!cmd_ready[d] && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
        end
        check("ready_wait", 64'(cmd_ready[d]), 64'd1);
        @(posedge clk);
        #1 cmd_valid[d] = 1'b0;
        for (int n = 1; n <= len + 2; n++) begin
            @(negedge clk);
            phy_rst_req[d] = (inj == 1 && n == 150);
            if (pm && !mdc[d]) nf++;
            if (!pm && mdc[d]) begin
                cap_o = {cap_o[62:0], mdio_o[d]};
                cap_t = {cap_t[62:0], mdio_t[d]};
            end
            pm = mdc[d];
            fb = nf - pre;
            mdio_i[d] = 1'b1;
            if (drive && fb == 15) mdio_i[d] = ta2;
            if (drive && fb >= 16 && fb <= 31) mdio_i[d] = pdata[31 - fb];
            if (rsp_valid[d]) begin
                n_rv++;
                rv_cyc  = n;
                rv_data = (d == 0) ? rsp_data0 : rsp_data1;
                rv_err  = rsp_err[d];
            end
            if (n == len + 2) rdy_after = cmd_ready[d];
        end
        mdio_i[d] = 1'b1;
    endtask

    initial begin
        int first_hi;
        int rdy_bad;
        int lo, rv, mc;

        // Power-up reset and PHY reset hold
        repeat (3) @(negedge clk);
        check("rst_vals0", 64'(rst_vec(0)), 64'h2C_0000);
        check("rst_vals1", 64'(rst_vec(1)), 64'h2C_0000);
        rst_n = 1'b1;
        first_hi = 0;
        rdy_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (phy_rst_n[0] && first_hi == 0) first_hi = k;
            if (cmd_ready[0] !== phy_rst_n[0]) rdy_bad++;
        end
        check("phy_rst_len", 64'(first_hi), 64'd10);
        check("ready_vs_rst", 64'(rdy_bad), 64'd0);

        // C22 write, phy 1 reg 0 data 0x1140
        run_frame(0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 1'b0, 1'b1, 16'h0000, 0);
        check("wr_bits", cap_o, 64'hFFFF_FFFF_5082_1140);
        check("wr_tri", cap_t, 64'h0);
        check("wr_nrv", 64'(n_rv), 64'd1);
        check("wr_cyc", 64'(rv_cyc), 64'd257);
        check("wr_data", 64'(rv_data), 64'h0);
        check("wr_err", 64'(rv_err), 64'h0);
        check("wr_ready", 64'(rdy_after), 64'd1);

        // C22 read phy 3 reg 2, PHY answers 0x0141
        run_frame(0, 1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, 1'b1, 1'b0, 16'h0141, 0);
        check("rd_bits", cap_o & 64'hFFFF_FFFF_FFFC_0000, 64'hFFFF_FFFF_6188_0000);
        check("rd_tri", cap_t, 64'h3_FFFF);
        check("rd_data", 64'(rv_data), 64'h0141);
        check("rd_err", 64'(rv_err), 64'h0);

        // Same read with a silent PHY
        run_frame(0, 1'b0, 2'b10, 5'd3, 5'd2, 16'h0000, 1'b0, 1'b1, 16'h0000, 0);
        check("rd_silent_data", 64'(rv_data), 64'hFFFF);
        check("rd_silent_err", 64'(rv_err), 64'h1);

        // C45 address then read, no preamble
        run_frame(1, 1'b1, 2'b00, 5'd2, 5'd1, 16'hABCD, 1'b0, 1'b1, 16'h0000, 0);
        check("c45a_bits", cap_o, 64'h0000_0000_0106_ABCD);
        check("c45a_tri", cap_t, 64'h0);
        check("c45a_cyc", 64'(rv_cyc), 64'd129);
        check("c45a_ready", 64'(rdy_after), 64'd1);
        run_frame(1, 1'b1, 2'b11, 5'd2, 5'd1, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 0);
        check("c45r_bits", cap_o & 64'h0000_0000_FFFC_0000, 64'h0000_0000_3104_0000);
        check("c45r_tri", cap_t, 64'h3_FFFF);
        check("c45r_cyc", 64'(rv_cyc), 64'd129);
        check("c45r_data", 64'(rv_data), 64'hBEEF);

        // phy_rst_req during a read: frame completes, then PHY reset
        run_frame(0, 1'b0, 2'b10, 5'd4, 5'd1, 16'h0000, 1'b1, 1'b0, 16'h1234, 1);
        check("prq_nrv", 64'(n_rv), 64'd1);
        check("prq_data", 64'(rv_data), 64'h1234);
        check("prq_ready", 64'(rdy_after), 64'd0);
        lo = 0;
        for (int k = 0; k < 30; k++) begin
            if (!phy_rst_n[0]) lo++;
            @(negedge clk);
        end
        check("prq_rst_len", 64'(lo), 64'd10);

        // phy_rst_req wins over a simultaneous cmd_valid in IDLE
        check("idle_ready", 64'(cmd_ready[0]), 64'd1);
        cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_data = 16'h5555;
        cmd_valid[0] = 1'b1;
        phy_rst_req[0] = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        phy_rst_req[0] = 1'b0;
        lo = 0; rv = 0; mc = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!phy_rst_n[0]) lo++;
            if (rsp_valid[0]) rv++;
            if (mdc[0]) mc++;
        end
        check("simul_rst_len", 64'(lo), 64'd10);
        check("simul_no_rsp", 64'(rv), 64'd0);
        check("simul_no_mdc", 64'(mc), 64'd0);
        check("simul_idle", 64'(busy[0]), 64'd0);

        // rst_n asserted mid-frame
        cmd_c45 = 1'b0; cmd_op = 2'b01; cmd_phy = 5'd7; cmd_reg = 5'd9; cmd_data = 16'h0F0F;
        cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_busy", 64'(busy[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vals0", 64'(rst_vec(0)), 64'h2C_0000);
        check("mid_rst_vals1", 64'(rst_vec(1)), 64'h2C_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rsp_valid[0] || rsp_valid[1]) rv++;
        end
        check("mid_no_rsp", 64'(rv), 64'd0);
        check("mid_rerelease", 64'(phy_rst_n[0]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
